// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared MDControl encodings and md_unit FSM state encoding
// Ports: none (package). Imported by md_unit and by the main controller decode.
package md_defs;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 32-bit multiply/divide datapath
// Ports:
//   a, b            : 32-bit operands (rs, rt)
//   prod_s, prod_u  : 64-bit signed / unsigned products
//   quot_s, rem_s   : signed quotient (toward zero) / remainder (dividend sign)
//   quot_u, rem_u   : unsigned quotient / remainder
//   div_zero        : divisor is zero; quotient/remainder outputs are don't-care
module md_arith (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] prod_s,
   output logic [63:0] prod_u,
   output logic [31:0] quot_s,
   output logic [31:0] rem_s,
   output logic [31:0] quot_u,
   output logic [31:0] rem_u,
   output logic        div_zero
);

   logic [63:0] a_sx, b_sx;
   logic [31:0] a_mag, b_mag, b_safe, bs_safe;
   logic [31:0] q_mag, r_mag;

   always_comb begin
      a_sx = {{32{a[31]}}, a};
      b_sx = {{32{b[31]}}, b};
      // The low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, a} * {32'd0, b};

      div_zero = (b == 32'd0);
      // Divisor forced to 1 when zero so the dividers never see a zero operand.
      b_safe   = div_zero ? 32'd1 : b;
      quot_u   = a / b_safe;
      rem_u    = a % b_safe;

      // Signed division on magnitudes; -0x80000000 as unsigned is 0x80000000, so the
      // 0x80000000 / -1 overflow case falls out as quotient 0x80000000, remainder 0.
      a_mag   = a[31] ? (32'd0 - a) : a;
      b_mag   = b[31] ? (32'd0 - b) : b;
      bs_safe = div_zero ? 32'd1 : b_mag;
      q_mag   = a_mag / bs_safe;
      r_mag   = a_mag % bs_safe;
      quot_s  = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
      rem_s   = a[31] ? (32'd0 - r_mag) : r_mag;
   end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning architectural HI/LO
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   EXC_flush        : cancels an op offered in the same cycle
//   Start            : op-valid strobe; MDControl selects the op
//   A, B             : forwarded rs/rt operands, sampled only at the accepting edge
//   Busy             : registered, high for exactly N cycles of an accepted mult/div
//   HI, LO           : architectural HI/LO registers
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        EXC_flush,
   input  logic        Start,
   input  logic [2:0]  MDControl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic             busy_q, busy_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic        div_zero;
   logic        accept;

   md_arith u_arith (
      .a        (A),
      .b        (B),
      .prod_s   (prod_s),
      .prod_u   (prod_u),
      .quot_s   (quot_s),
      .rem_s    (rem_s),
      .quot_u   (quot_u),
      .rem_u    (rem_u),
      .div_zero (div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      busy_d    = busy_q;

      accept = Start && !EXC_flush && (state_q == ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (MDControl)
                  MD_MULT, MD_MULTU: begin
                     {pend_hi_d, pend_lo_d} = (MDControl == MD_MULT) ? prod_s : prod_u;
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = ST_BUSY;
                     busy_d    = 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     pend_lo_d = (MDControl == MD_DIV) ? quot_s : quot_u;
                     pend_hi_d = (MDControl == MD_DIV) ? rem_s  : rem_u;
                     // Divide by zero still occupies the unit but leaves HI/LO untouched.
                     pend_wr_d = !div_zero;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_BUSY;
                     busy_d    = 1'b1;
                  end
                  MD_MTHI: hi_d = A;
                  MD_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;
   import md_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        EXC_flush;
   logic        Start;
   logic [2:0]  MDControl;
   logic [31:0] A, B;
   logic        Busy;
   logic [31:0] HI, LO;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .EXC_flush (EXC_flush),
      .Start     (Start),
      .MDControl (MDControl),
      .A         (A),
      .B         (B),
      .Busy      (Busy),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Issues one op at a negedge, then walks the Busy window. At busy cycle inj_at it
   // drives Start/EXC_flush with an mthi of 0xDEADBEEF, which must have no effect.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic commit,
                         input logic [31:0] hi_new, input logic [31:0] lo_new,
                         input int inj_at, input logic inj_start, input logic inj_flush);
      int   cnt;
      logic held;
      @(negedge clk);
      Start = 1'b1; MDControl = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; A = $urandom; B = $urandom;
      cnt  = 0;
      held = 1'b1;
      while (Busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (HI !== exp_hi || LO !== exp_lo) held = 1'b0;
         if (cnt == inj_at) begin
            Start = inj_start; EXC_flush = inj_flush;
            MDControl = MD_MTHI; A = 32'hDEADBEEF;
         end else begin
            Start = 1'b0; EXC_flush = 1'b0;
         end
         @(negedge clk);
      end
      Start = 1'b0; EXC_flush = 1'b0;
      chk($sformatf("%s busy_cycles", tag), 32'(cnt), 32'(n));
      chk($sformatf("%s old_hilo_held", tag), {31'd0, held}, 32'd1);
      if (commit) begin
         exp_hi = hi_new;
         exp_lo = lo_new;
      end
      chk($sformatf("%s HI", tag), HI, exp_hi);
      chk($sformatf("%s LO", tag), LO, exp_lo);
   endtask

   initial begin
      reset = 1'b0; EXC_flush = 1'b0; Start = 1'b0;
      MDControl = 3'b000; A = 32'd0; B = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset Busy", {31'd0, Busy}, 32'd0);
      chk("reset HI", HI, 32'd0);
      chk("reset LO", LO, 32'd0);
      reset = 1'b1;

      // mthi then mtlo back to back
      @(negedge clk);
      Start = 1'b1; MDControl = MD_MTHI; A = 32'h12345678;
      @(negedge clk);
      chk("mthi HI", HI, 32'h12345678);
      chk("mthi Busy", {31'd0, Busy}, 32'd0);
      MDControl = MD_MTLO; A = 32'h9ABCDEF0;
      @(negedge clk);
      Start = 1'b0;
      chk("mtlo LO", LO, 32'h9ABCDEF0);
      chk("mtlo HI", HI, 32'h12345678);
      chk("mtlo Busy", {31'd0, Busy}, 32'd0);
      exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;

      run_op("mult -2*3", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b1,
             32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1'b0, 1'b0);
      run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b1,
             32'h00000001, 32'hFFFFFFFE, 0, 1'b0, 1'b0);
      run_op("mult neg*neg", MD_MULT, 32'h80000000, 32'h80000000, 5, 1'b1,
             32'h40000000, 32'h00000000, 0, 1'b0, 1'b0);
      run_op("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b1,
             32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0, 1'b0);
      run_op("div by zero", MD_DIV, 32'h00001234, 32'd0, 10, 1'b0,
             32'd0, 32'd0, 0, 1'b0, 1'b0);
      run_op("div overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b1,
             32'h00000000, 32'h80000000, 0, 1'b0, 1'b0);
      run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 10, 1'b1,
             32'h00000001, 32'h7FFFFFFC, 0, 1'b0, 1'b0);
      run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 1'b1,
             32'h00000001, 32'hFFFFFFFD, 0, 1'b0, 1'b0);

      // Start+flush together: op dropped
      @(negedge clk);
      Start = 1'b1; EXC_flush = 1'b1; MDControl = MD_MULT; A = 32'd9; B = 32'd9;
      @(negedge clk);
      Start = 1'b0; EXC_flush = 1'b0;
      chk("flush drop Busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      chk("flush drop Busy2", {31'd0, Busy}, 32'd0);
      chk("flush drop HI", HI, exp_hi);
      chk("flush drop LO", LO, exp_lo);

      // Reserved encoding: no effect
      @(negedge clk);
      Start = 1'b1; MDControl = 3'b110; A = 32'h55555555; B = 32'd3;
      @(negedge clk);
      Start = 1'b0;
      chk("reserved Busy", {31'd0, Busy}, 32'd0);
      chk("reserved HI", HI, exp_hi);
      chk("reserved LO", LO, exp_lo);

      // Flush during busy: in-flight div still commits; Start while busy ignored
      run_op("div flush@3", MD_DIV, 32'd100, 32'd7, 10, 1'b1,
             32'd2, 32'd14, 3, 1'b1, 1'b1);
      run_op("mult start@2", MD_MULT, 32'd6, 32'd7, 5, 1'b1,
             32'd0, 32'd42, 2, 1'b1, 1'b0);

      // Async reset mid-operation
      @(negedge clk);
      Start = 1'b1; MDControl = MD_MULT; A = 32'd5; B = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      chk("rst-mid busy c1", {31'd0, Busy}, 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst-mid Busy", {31'd0, Busy}, 32'd0);
      chk("rst-mid HI", HI, 32'd0);
      chk("rst-mid LO", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_hi = 32'd0; exp_lo = 32'd0;
      repeat (8) @(negedge clk);
      chk("post-rst Busy", {31'd0, Busy}, 32'd0);
      chk("post-rst HI", HI, 32'd0);
      chk("post-rst LO", LO, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the pipeline control layer.
- Consumes the control layer's Start, MDControl and EXC_flush, plus rs/rt operands forwarded in EX.
- Owns the architectural HI/LO registers. Returns Busy to the control layer, which stalls with (Start | Busy).
- Fixed-latency model: result computed at issue, held in pending registers, committed to HI/LO when a down-counter expires.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- EXC_flush  input  1  exception/eret flush of the EX instruction; cancels any op offered this cycle.
- Start  input  1  op-valid strobe for the EX instruction.
- MDControl  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register (mfhi source).
- LO  output  32  architectural LO register (mflo source).

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, Busy=0, counter=0, pending regs=0, state=IDLE.
- Accept condition: Start=1 & EXC_flush=0 & state=IDLE. Otherwise the offer is ignored, including Start while BUSY (a protocol violation the stall logic prevents).
- FSM states:
  - IDLE: accepting mult/multu/div/divu at edge t -> BUSY. counter loads MULT_CYCLES or DIV_CYCLES. Busy=1 from cycle t+1.
  - BUSY: counter decrements each edge. On the edge where counter==1: pending HI/LO are written, Busy->0, state->IDLE. Busy is therefore high for exactly N cycles and the new HI/LO are visible in the first cycle Busy=0.
- mthi/mtlo: accepted in IDLE, writes A to HI/LO at the accepting edge, single-cycle, Busy stays 0.
- Reserved MDControl values: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64; {HI,LO}=product.
  - multu: unsigned 32x32 -> 64; {HI,LO}=product.
  - div/divu: LO=quotient, HI=remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): op still runs DIV_CYCLES with Busy, but HI/LO are left unchanged at completion.
- EXC_flush while BUSY: in-flight op continues and commits (it belongs to an older, committed instruction).
- EXC_flush with Start in the same cycle: op dropped, no state change.
- Operands are sampled only at the accepting edge; later changes to A/B have no effect.
- HI/LO outputs are the architectural values only; pending results never appear before commit.
- Async reset mid-operation: aborts the op, all state returns to reset values, pending result discarded.

Decomposition:
- Shared package (md_defs): MDControl encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and FSM state encoding (ST_IDLE, ST_BUSY), also used by the main controller decode.
- One natural sub-module, md_arith: combinational signed/unsigned product, quotient and remainder, plus the div-by-zero flag.
- The md_unit top holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- Reset then mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0, Busy never high.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA in the first cycle Busy=0, old HI/LO held until then.
- multu A=0xFFFFFFFF, B=2 -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat div with B=0 -> 10 Busy cycles, HI/LO unchanged.
- Start=1 mult with EXC_flush=1 -> Busy stays 0, HI/LO unchanged. Div in flight with EXC_flush pulsed at busy cycle 3 -> completes normally at cycle 10.
- Mult in flight, drive reset=0 for 1 cycle at busy cycle 2 (asynchronously, mid-cycle) -> Busy, HI, LO go 0 immediately; no commit occurs afterwards.
